// File: rtl/fp16_pkg.sv
// Shared FP16 constants and types for the fp16_mul_stream slice.
package fp16_pkg;
  localparam int DWIDTH = 16;
  localparam int EWIDTH = 5;
  localparam int MWIDTH = 10;
  localparam int BIAS   = 15;

  typedef struct packed {
    logic              sign;
    logic [EWIDTH-1:0] exp;
    logic [MWIDTH-1:0] mant;
  } fp16_t;

  typedef struct packed {
    logic exc;
    logic ovf;
    logic unf;
  } fp_flags_t;
endpackage

// File: rtl/fp16_mul.sv
// Combinational binary-float multiplier core.
// - Subnormal operands are treated as zero.
// - Rounding is round-to-nearest-even.
// - Exception: either operand is Inf or NaN. The result is a signed Inf, or a
//   quiet NaN for a NaN operand or Inf*0.
// - Overflow: the rounded exponent reaches the all-ones exponent. The result
//   is a signed Inf.
// - Underflow: the rounded exponent is <= 0. The result is flushed to a
//   signed zero.
module fp16_mul
  import fp16_pkg::*;
#(
  parameter int EWIDTH = fp16_pkg::EWIDTH,
  parameter int MWIDTH = fp16_pkg::MWIDTH,
  parameter int BIAS   = fp16_pkg::BIAS
) (
  input  logic [EWIDTH+MWIDTH:0] a_operand,
  input  logic [EWIDTH+MWIDTH:0] b_operand,
  output logic [EWIDTH+MWIDTH:0] result,
  output logic                   exception,
  output logic                   overflow,
  output logic                   underflow
);
  localparam int PW   = 2*(MWIDTH+1);
  localparam int XW   = EWIDTH+3;
  localparam int EMAX = (1 << EWIDTH) - 1;

  logic              sa, sb, sign;
  logic [EWIDTH-1:0] ea, eb;
  logic [MWIDTH-1:0] fa, fb;
  logic              a_max, b_max, a_zero, b_zero, a_nan, b_nan, zero_in, is_nan;
  logic [PW-1:0]     prod, prod_n;
  logic              norm, guard, sticky, round_up, carry;
  logic [MWIDTH-1:0] frac;
  logic [MWIDTH:0]   frac_r;
  logic [XW-1:0]     exp_s;

  assign {sa, ea, fa} = a_operand;
  assign {sb, eb, fb} = b_operand;
  assign sign    = sa ^ sb;
  assign a_max   = &ea;
  assign b_max   = &eb;
  assign a_zero  = (ea == '0);
  assign b_zero  = (eb == '0);
  assign a_nan   = a_max && (|fa);
  assign b_nan   = b_max && (|fb);
  assign zero_in = a_zero || b_zero;
  assign is_nan  = a_nan || b_nan || (a_max && b_zero) || (b_max && a_zero);

  // Significand product, normalised so the leading one sits at bit PW-1.
  assign prod     = {1'b1, fa} * {1'b1, fb};
  assign norm     = prod[PW-1];
  assign prod_n   = norm ? prod : (prod << 1);
  assign frac     = prod_n[PW-2 -: MWIDTH];
  assign guard    = prod_n[PW-2-MWIDTH];
  assign sticky   = |prod_n[PW-3-MWIDTH:0];
  assign round_up = guard && (sticky || frac[0]);
  assign frac_r   = {1'b0, frac} + (MWIDTH+1)'(round_up);
  assign carry    = frac_r[MWIDTH];

  // Two's complement biased exponent after normalisation and rounding carry.
  assign exp_s = XW'(ea) + XW'(eb) - XW'(BIAS) + XW'(norm) + XW'(carry);

  assign exception = a_max || b_max;
  assign overflow  = !exception && !zero_in && !exp_s[XW-1] &&
                     (exp_s[XW-2:0] >= (XW-1)'(EMAX));
  assign underflow = !exception && !zero_in && (exp_s[XW-1] || (exp_s == '0));

  // Priority select of the packed result.
  always_comb begin
    result = {sign, exp_s[EWIDTH-1:0], frac_r[MWIDTH-1:0]};
    if (exception) begin
      if (is_nan) result = {1'b0, {EWIDTH{1'b1}}, 1'b1, {(MWIDTH-1){1'b0}}};
      else        result = {sign, {EWIDTH{1'b1}}, {MWIDTH{1'b0}}};
    end else if (zero_in || underflow) begin
      result = {sign, {(EWIDTH+MWIDTH){1'b0}}};
    end else if (overflow) begin
      result = {sign, {EWIDTH{1'b1}}, {MWIDTH{1'b0}}};
    end
  end
endmodule

// File: rtl/fp16_mul_stream.sv
// Two-stage elastic valid/ready wrapper around fp16_mul.
// - S1 registers the operands.
// - S2 registers the product and the flags.
// - Optional status block (sticky flags and saturating exception counter) is
//   built when FP16_MUL_STATUS_EN is defined.
module fp16_mul_stream
  import fp16_pkg::*;
#(
  parameter int DWIDTH = fp16_pkg::DWIDTH,
  parameter int EWIDTH = fp16_pkg::EWIDTH,
  parameter int MWIDTH = fp16_pkg::MWIDTH,
  parameter int BIAS   = fp16_pkg::BIAS,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DWIDTH-1:0] a_operand,
  input  logic [DWIDTH-1:0] b_operand,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DWIDTH-1:0] result,
  output logic              out_exception,
  output logic              out_overflow,
  output logic              out_underflow,
  input  logic              status_clr,
  output logic              sticky_exc,
  output logic              sticky_ovf,
  output logic              sticky_unf,
  output logic [CNT_W-1:0]  exc_count
);
  logic [DWIDTH-1:0] s1_a, s1_b, core_res;
  logic              s1_valid, s2_load, out_fire;
  fp_flags_t         core_flags, out_flags;

  assign s2_load  = s1_valid && (!out_valid || out_ready);
  // Combinational from out_ready so both stages can advance in one cycle.
  assign in_ready = !s1_valid || s2_load;
  assign out_fire = out_valid && out_ready;

  fp16_mul #(.EWIDTH(EWIDTH), .MWIDTH(MWIDTH), .BIAS(BIAS)) u_mul (
    .a_operand (s1_a),
    .b_operand (s1_b),
    .result    (core_res),
    .exception (core_flags.exc),
    .overflow  (core_flags.ovf),
    .underflow (core_flags.unf)
  );

  // S1: operand capture, emptied when S2 takes the pair.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
    end else if (in_valid && in_ready) begin
      s1_valid <= 1'b1;
      s1_a     <= a_operand;
      s1_b     <= b_operand;
    end else if (s2_load) begin
      s1_valid <= 1'b0;
    end
  end

  // S2: result and flag capture, held stable while the consumer stalls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      result    <= '0;
      out_flags <= '0;
    end else if (s2_load) begin
      out_valid <= 1'b1;
      result    <= core_res;
      out_flags <= core_flags;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  assign out_exception = out_flags.exc;
  assign out_overflow  = out_flags.ovf;
  assign out_underflow = out_flags.unf;

`ifdef FP16_MUL_STATUS_EN
  logic any_flag;
  assign any_flag = out_flags.exc || out_flags.ovf || out_flags.unf;

  // Status: a delivered flagged result overrides a same-cycle clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sticky_exc <= 1'b0;
      sticky_ovf <= 1'b0;
      sticky_unf <= 1'b0;
      exc_count  <= '0;
    end else begin
      if (status_clr) begin
        sticky_exc <= 1'b0;
        sticky_ovf <= 1'b0;
        sticky_unf <= 1'b0;
        exc_count  <= '0;
      end
      if (out_fire) begin
        if (out_flags.exc) sticky_exc <= 1'b1;
        if (out_flags.ovf) sticky_ovf <= 1'b1;
        if (out_flags.unf) sticky_unf <= 1'b1;
        if (any_flag) begin
          if (status_clr)             exc_count <= CNT_W'(1);
          else if (exc_count != '1)   exc_count <= exc_count + CNT_W'(1);
        end
      end
    end
  end
`else
  logic unused_status;
  assign unused_status = status_clr ^ out_fire;
  assign sticky_exc = 1'b0;
  assign sticky_ovf = 1'b0;
  assign sticky_unf = 1'b0;
  assign exc_count  = '0;
`endif
endmodule

// File: tb/tb_fp16_mul_stream.sv
// Scoreboard bench for fp16_mul_stream: the driver pushes hand-computed
// expectations when a pair is accepted, and the monitor pops and compares
// on every output handshake.
module tb_fp16_mul_stream;
`ifdef FP16_MUL_STATUS_EN
  localparam bit STATUS = 1'b1;
`else
  localparam bit STATUS = 1'b0;
`endif

  logic        clk = 1'b0, rst = 1'b1;
  logic        in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b1;
  logic [15:0] a_operand = '0, b_operand = '0, result;
  logic        out_exception, out_overflow, out_underflow;
  logic        status_clr = 1'b0, sticky_exc, sticky_ovf, sticky_unf;
  logic [15:0] exc_count;

  int tests = 0, fails = 0, cyc = 0;
  logic [18:0] exp_q[$];
  int          pop_cyc[$];

  fp16_mul_stream dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a_operand(a_operand), .b_operand(b_operand), .out_valid(out_valid),
    .out_ready(out_ready), .result(result), .out_exception(out_exception),
    .out_overflow(out_overflow), .out_underflow(out_underflow),
    .status_clr(status_clr), .sticky_exc(sticky_exc), .sticky_ovf(sticky_ovf),
    .sticky_unf(sticky_unf), .exc_count(exc_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  // Monitor: compare every delivered result against the scoreboard head.
  always @(negedge clk) begin
    logic [18:0] e;
    cyc++;
    if (!rst && out_valid && out_ready) begin
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_out: got 0x%0h with empty scoreboard", result);
      end else begin
        e = exp_q.pop_front();
        pop_cyc.push_back(cyc);
        if ({result, out_exception, out_overflow, out_underflow} !== e) begin
          fails++;
          $display("FAIL result: got %h e%b o%b u%b, expected %h e%b o%b u%b",
                   result, out_exception, out_overflow, out_underflow,
                   e[18:3], e[2], e[1], e[0]);
        end
      end
    end
  end

  // Drive one pair and push its expectation when it is accepted.
  task automatic send(input logic [15:0] a, input logic [15:0] b,
                      input logic [15:0] r, input logic [2:0] f);
    int n = 0;
    a_operand = a; b_operand = b; in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 100) begin @(negedge clk); n++; end
    if (n >= 100) check("send_timeout", 32'd1, 32'd0);
    else exp_q.push_back({r, f});
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Wait until every expectation has been delivered, then let status settle.
  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) check("drain_timeout", 32'(exp_q.size()), 32'd0);
    @(posedge clk); #1;
  endtask

  task automatic wait_out_valid();
    int n = 0;
    @(negedge clk);
    while (!out_valid && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) check("out_valid_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    logic [15:0] held;
    #12;
    check("rst_in_ready",  32'(in_ready),  32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_result",    32'(result),    32'd0);
    check("rst_exc_count", 32'(exc_count), 32'd0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;

    // Single pairs with latency check on the first.
    send(16'h3C00, 16'h3C00, 16'h3C00, 3'b000);
    check("lat_s1_only", 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    check("lat_out_valid", 32'(out_valid), 32'd1);
    drain();
    send(16'h3C00, 16'h4200, 16'h4200, 3'b000); drain();
    send(16'h3C00, 16'h4700, 16'h4700, 3'b000); drain();
    send(16'h3C00, 16'h4B80, 16'h4B80, 3'b000); drain();
    send(16'hC000, 16'h3C00, 16'hC000, 3'b000); drain();  // sign
    send(16'h3C01, 16'h3E00, 16'h3E02, 3'b000); drain();  // tie to even
    send(16'h3FFF, 16'h3FFF, 16'h43FE, 3'b000); drain();  // normalise shift
    send(16'h0000, 16'h4200, 16'h0000, 3'b000); drain();  // zero operand

    // Back-to-back stream: one result per cycle.
    pop_cyc.delete();
    send(16'h3C00, 16'h3C00, 16'h3C00, 3'b000);
    send(16'h3C00, 16'h4200, 16'h4200, 3'b000);
    send(16'h3C00, 16'h4700, 16'h4700, 3'b000);
    send(16'h3C00, 16'h4B80, 16'h4B80, 3'b000);
    drain();
    check("stream_count", 32'(pop_cyc.size()), 32'd4);
    for (int k = 0; k < 3 && k + 1 < pop_cyc.size(); k++)
      check("stream_gap", 32'(pop_cyc[k+1] - pop_cyc[k]), 32'd1);

    // Backpressure: both stages fill, in_ready drops, output holds.
    out_ready = 1'b0;
    send(16'h3C00, 16'h4200, 16'h4200, 3'b000);
    send(16'h3C00, 16'h4700, 16'h4700, 3'b000);
    @(negedge clk);
    check("bp_in_ready", 32'(in_ready), 32'd0);
    check("bp_out_valid", 32'(out_valid), 32'd1);
    held = result;
    check("bp_head", 32'(held), 32'h4200);
    repeat (3) @(negedge clk);
    check("bp_stable", 32'(result), 32'(held));
    @(posedge clk); #1; out_ready = 1'b1;
    drain();

    // Flags and status counter.
    status_clr = 1'b1; @(posedge clk); #1; status_clr = 1'b0;
    send(16'h7BFF, 16'h7BFF, 16'h7C00, 3'b010); drain();
    check("ovf_sticky", 32'(sticky_ovf), 32'(STATUS));
    check("ovf_count",  32'(exc_count),  STATUS ? 32'd1 : 32'd0);
    send(16'h7C00, 16'h3C00, 16'h7C00, 3'b100); drain();
    check("exc_sticky", 32'(sticky_exc), 32'(STATUS));
    check("exc_count2", 32'(exc_count),  STATUS ? 32'd2 : 32'd0);

    // Clear coincident with a flagged handshake: event wins.
    out_ready = 1'b0;
    send(16'h0400, 16'h0400, 16'h0000, 3'b001);
    wait_out_valid();
    @(posedge clk); #1;
    status_clr = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    status_clr = 1'b0;
    check("clr_evt_unf",   32'(sticky_unf), 32'(STATUS));
    check("clr_evt_count", 32'(exc_count),  STATUS ? 32'd1 : 32'd0);
    drain();
    status_clr = 1'b1; @(posedge clk); #1; status_clr = 1'b0;
    check("clr_sticky", 32'({sticky_exc, sticky_ovf, sticky_unf}), 32'd0);
    check("clr_count",  32'(exc_count), 32'd0);

    // Reset while both stages are full drops everything at once.
    out_ready = 1'b0;
    send(16'h3C00, 16'h4200, 16'h4200, 3'b000);
    send(16'h3C00, 16'h4700, 16'h4700, 3'b000);
    @(negedge clk);
    check("full_in_ready", 32'(in_ready), 32'd0);
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    check("arst_out_valid", 32'(out_valid), 32'd0);
    check("arst_in_ready",  32'(in_ready),  32'd1);
    exp_q.delete();
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1; out_ready = 1'b1;
    repeat (5) @(negedge clk);
    check("post_rst_idle", 32'(out_valid), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/fp16_mul_stream.md
# fp16_mul_stream

Elastic two-stage pipeline wrapper around the combinational `fp16_mul` core. It accepts FP16 operand pairs on a valid/ready stream, registers them, and evaluates the product through `fp16_mul`. The product and the core's Exception/Overflow/Underflow flags are captured into an output register, which drives a downstream valid/ready stream. The block is the stage between the operand producer and the result consumer, and gives the combinational multiplier a defined latency, backpressure and status reporting.

## Interface
- `DWIDTH`, 16: operand/result width.
- `EWIDTH`, 5: exponent width, passed to `fp16_mul`.
- `MWIDTH`, 10: mantissa width, passed to `fp16_mul`.
- `BIAS`, 15: exponent bias, passed to `fp16_mul`.
- `CNT_W`, 16: width of the exception event counter.
- `clk`  in  1  clock; all state updates on rising edge.
- `rst`  in  1  reset, asynchronous and active-high.
- `in_valid`  in  1  operand pair valid.
- `in_ready`  out  1  block can accept an operand pair.
- `a_operand`  in  DWIDTH  operand A (FP16).
- `b_operand`  in  DWIDTH  operand B (FP16).
- `out_valid`  out  1  result valid.
- `out_ready`  in  1  consumer accepts result.
- `result`  out  DWIDTH  registered product.
- `out_exception`  out  1  registered Exception flag of this result.
- `out_overflow`  out  1  registered Overflow flag of this result.
- `out_underflow`  out  1  registered Underflow flag of this result.
- `status_clr`  in  1  synchronous clear of sticky flags and counter.
- `sticky_exc`, `sticky_ovf`, `sticky_unf`  out  1 each  sticky status flags.
- `exc_count`  out  CNT_W  count of delivered results with any flag set.

## Operation
- Stage 1 (S1) holds the operand registers `s1_a` and `s1_b`, plus `s1_valid`. `fp16_mul` is fed from the S1 registers only, never from the raw input ports.
- Stage 2 (S2) holds the output registers `result`, the three flags, and `out_valid`.
- S2 handshake logic:
  - `s2_load = s1_valid && (!out_valid || out_ready)`.
  - On `s2_load`, S2 captures the core outputs and `out_valid <= 1`.
  - Otherwise, if `out_ready`, then `out_valid <= 0`.
- S1 handshake logic:
  - `in_ready = !s1_valid || s2_load`. This is combinational from `out_ready`; the path is intentional and gives full throughput.
  - On `in_valid && in_ready`, S1 captures the operands and `s1_valid <= 1`.
  - Otherwise, if `s2_load`, then `s1_valid <= 0`.
- While `out_valid && !out_ready`, `result` and the out flags hold stable. S1 then holds too, and `in_ready` deasserts once S1 is full.
- Result arithmetic, rounding and flag semantics are exactly those of `fp16_mul`. This block performs no arithmetic of its own.
- Status (see Configuration):
  - On an output handshake (`out_valid && out_ready`), each set out flag sets its sticky flag.
  - If any out flag is set, `exc_count` increments, saturating at all-ones.
  - `status_clr` clears the sticky flags and `exc_count`. If a handshake event occurs in the same cycle, the event wins: sticky flags end set and `exc_count` ends at 1.

## Timing
- Reset values:
  - `in_ready` = 1 (combinational, because `s1_valid` = 0).
  - `out_valid` = 0, `result` = 0, and all out flags = 0.
  - Sticky flags = 0 and `exc_count` = 0.
  - `s1_a`/`s1_b` = 0.
- Latency: operands accepted at edge N produce `out_valid` = 1 after edge N+1, assuming no stall.
- Throughput: one result per clock with `out_ready` held at 1.
- With `out_ready` low and both stages full, two pairs are buffered. In that state `in_ready` = 0.
- When `out_ready` rises, both stages advance in the same cycle. The input may be accepted in that cycle.
- Reset asserted mid-stream drops all in-flight data immediately (asynchronously). No partial result appears after reset release.
- `out_valid` never drops without a handshake.

## Configuration
- `FP16_MUL_STATUS_EN` defined: sticky flags and `exc_count` are implemented as described above.
- `FP16_MUL_STATUS_EN` undefined: the status registers are not built. `sticky_*` and `exc_count` are tied to 0 and `status_clr` is ignored. Datapath and handshake behaviour are identical in both cases.

## Structure
- Shared package `fp16_pkg` holds:
  - the DWIDTH/EWIDTH/MWIDTH/BIAS constants;
  - a packed FP16 struct typedef (sign/exp/mant);
  - a flags struct typedef (exc/ovf/unf).
- One sub-module: `fp16_mul`, instantiated with the package constants. All sequential logic lives in `fp16_mul_stream`.

## Test plan
- Single pairs, `out_ready` = 1:
  - 0x3C00×0x3C00 → `result` 0x3C00 two cycles after accept.
  - 0x3C00×0x4200 → 0x4200.
  - 0x3C00×0x4700 → 0x4700.
  - 0x3C00×0x4B80 → 0x4B80.
  - Flags are 0 in all four cases.
- Back-to-back stream of the four pairs above, with `in_valid` and `out_ready` held at 1 → four consecutive `out_valid` cycles, in order, with no bubbles.
- Backpressure: `out_ready` = 0 after the first result → `in_ready` falls after the second accept and `result` stays stable. Releasing `out_ready` drains both results in order, with no loss or duplication.
- Operands 0x7BFF×0x7BFF → `out_overflow` = 1, `sticky_ovf` = 1 after the handshake, and `exc_count` = 1. Operands 0x7C00×0x3C00 → `out_exception` = 1 and `exc_count` = 2.
- `status_clr` pulsed in the same cycle as a flagged handshake → `sticky_*` remain set and `exc_count` = 1. `status_clr` pulsed alone → all cleared. With `FP16_MUL_STATUS_EN` undefined → `exc_count` stays 0.
- `rst` asserted while both stages are full → `out_valid` = 0 and `in_ready` = 1 immediately. No stale result appears after release.
